// File: rtl/fifo_level_monitor.sv
// fifo_level_monitor
//   Multi-channel FIFO occupancy monitor. Each channel registers its FIFO
//   word count and runs a LOW/READY/FULL level FSM with hysteresis. Entry
//   into FULL is immediate; every other state change must persist for
//   HOLD_CYC consecutive samples before it commits.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   fifo_num      packed per-channel levels, channel i at [i*W +: W]
//   clr_ovf       per-channel single-cycle clear of ovf_sticky (and peak reload)
//   fifo_full_h   channel in FULL
//   fifo_ready_h  channel in READY or FULL
//   any_full_h    OR of fifo_full_h
//   all_ready_h   AND of fifo_ready_h
//   ovf_sticky    level exceeded DEPTH since last clear
//   peak_num      per-channel peak level (0 when peak tracking is not built)
//
// Build option
//   FIFO_LEVEL_PEAK_EN  when defined, builds per-channel peak registers;
//                       otherwise peak_num is tied to 0.
//
// State table
//   ST_LOW   | level at or below READY_LO, or not yet above READY_HI
//   ST_READY | data available, not in backpressure
//   ST_FULL  | backpressure asserted, held until level <= FULL_LO

module fifo_level_monitor #(
  parameter int CH       = 4,
  parameter int W        = 11,
  parameter int DEPTH    = 1024,
  parameter int FULL_HI  = 1000,
  parameter int FULL_LO  = 900,
  parameter int READY_HI = 10,
  parameter int READY_LO = 4,
  parameter int HOLD_CYC = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH*W-1:0] fifo_num,
  input  logic [CH-1:0]   clr_ovf,
  output logic [CH-1:0]   fifo_full_h,
  output logic [CH-1:0]   fifo_ready_h,
  output logic            any_full_h,
  output logic            all_ready_h,
  output logic [CH-1:0]   ovf_sticky,
  output logic [CH*W-1:0] peak_num
);

  localparam int CW = $clog2(HOLD_CYC + 1);

  localparam logic [W-1:0]  FULL_HI_W  = W'(FULL_HI);
  localparam logic [W-1:0]  FULL_LO_W  = W'(FULL_LO);
  localparam logic [W-1:0]  READY_HI_W = W'(READY_HI);
  localparam logic [W-1:0]  READY_LO_W = W'(READY_LO);
  localparam logic [W-1:0]  DEPTH_W    = W'(DEPTH);
  localparam logic [CW-1:0] HOLD_C     = CW'(HOLD_CYC);

  // Threshold ordering is checked at elaboration so a bad override fails early.
  if (!(CH >= 1 && HOLD_CYC >= 1 && READY_LO < READY_HI && READY_HI <= FULL_LO &&
        FULL_LO < FULL_HI && FULL_HI <= DEPTH && DEPTH < (1 << W))) begin : g_param_err
    $error("fifo_level_monitor: threshold parameters out of order");
  end

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_READY = 2'd1,
    ST_FULL  = 2'd2
  } lvl_state_e;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [W-1:0]  lvl_q;
    lvl_state_e    state_q, state_d;
    lvl_state_e    pend_q, pend_d;
    lvl_state_e    tgt;
    logic [CW-1:0] cnt_q, cnt_d, cnt_next;
    logic          ovf_q, ovf_d;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lvl_q   <= '0;
        state_q <= ST_LOW;
        pend_q  <= ST_LOW;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        lvl_q   <= fifo_num[i*W +: W];
        state_q <= state_d;
        pend_q  <= pend_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
      end
    end

    always_comb begin
      tgt = state_q;
      case (state_q)
        ST_LOW: begin
          if (lvl_q > FULL_HI_W)       tgt = ST_FULL;
          else if (lvl_q > READY_HI_W) tgt = ST_READY;
          else                         tgt = ST_LOW;
        end
        ST_READY: begin
          if (lvl_q > FULL_HI_W)        tgt = ST_FULL;
          else if (lvl_q <= READY_LO_W) tgt = ST_LOW;
          else                          tgt = ST_READY;
        end
        ST_FULL: begin
          if (lvl_q <= READY_LO_W)     tgt = ST_LOW;
          else if (lvl_q <= FULL_LO_W) tgt = ST_READY;
          else                         tgt = ST_FULL;
        end
        default: tgt = ST_LOW;
      endcase
    end

    always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      cnt_d    = cnt_q;
      cnt_next = '0;
      if (tgt == state_q) begin
        cnt_d = '0;
      end else if (tgt == ST_FULL) begin
        // Backpressure must not wait for the debounce.
        state_d = ST_FULL;
        pend_d  = ST_FULL;
        cnt_d   = '0;
      end else begin
        // A new or changed target restarts the persistence count at 1.
        if (tgt != pend_q || cnt_q == '0) begin
          pend_d   = tgt;
          cnt_next = CW'(1);
        end else begin
          cnt_next = cnt_q + CW'(1);
        end
        if (cnt_next == HOLD_C) begin
          state_d = tgt;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_next;
        end
      end
    end

    // A fresh overflow sample wins over a clear in the same cycle.
    always_comb begin
      ovf_d = ovf_q;
      if (lvl_q > DEPTH_W)  ovf_d = 1'b1;
      else if (clr_ovf[i])  ovf_d = 1'b0;
    end

    assign fifo_full_h[i]  = (state_q == ST_FULL);
    assign fifo_ready_h[i] = (state_q != ST_LOW);
    assign ovf_sticky[i]   = ovf_q;

`ifdef FIFO_LEVEL_PEAK_EN
    logic [W-1:0] peak_q, peak_d;

    always_comb begin
      peak_d = peak_q;
      if (clr_ovf[i])           peak_d = lvl_q;
      else if (lvl_q > peak_q)  peak_d = lvl_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) peak_q <= '0;
      else          peak_q <= peak_d;
    end

    assign peak_num[i*W +: W] = peak_q;
`endif
  end

`ifndef FIFO_LEVEL_PEAK_EN
  assign peak_num = '0;
`endif

  assign any_full_h  = |fifo_full_h;
  assign all_ready_h = &fifo_ready_h;

endmodule

// File: tb/tb_fifo_level_monitor.sv
// tb_fifo_level_monitor
//   Directed-vector bench for fifo_level_monitor with CH=2 and default
//   thresholds. Inputs change 1 ns after a rising edge; outputs are read
//   at the same point, i.e. after the edge has settled.

module tb_fifo_level_monitor;

  localparam int CH = 2;
  localparam int W  = 11;

  logic            clk;
  logic            reset_n;
  logic [CH*W-1:0] fifo_num;
  logic [CH-1:0]   clr_ovf;
  logic [CH-1:0]   fifo_full_h;
  logic [CH-1:0]   fifo_ready_h;
  logic            any_full_h;
  logic            all_ready_h;
  logic [CH-1:0]   ovf_sticky;
  logic [CH*W-1:0] peak_num;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_level_monitor #(.CH(CH), .W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_num     (fifo_num),
    .clr_ovf      (clr_ovf),
    .fifo_full_h  (fifo_full_h),
    .fifo_ready_h (fifo_ready_h),
    .any_full_h   (any_full_h),
    .all_ready_h  (all_ready_h),
    .ovf_sticky   (ovf_sticky),
    .peak_num     (peak_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lvl(input int ch, input logic [W-1:0] v);
    fifo_num[ch*W +: W] = v;
  endtask

  task automatic pulse_clr(input int ch);
    clr_ovf[ch] = 1'b1;
    step(1);
    clr_ovf[ch] = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_full"},  32'(fifo_full_h),  32'h0);
    check_eq({tag, "_ready"}, 32'(fifo_ready_h), 32'h0);
    check_eq({tag, "_any"},   32'(any_full_h),   32'h0);
    check_eq({tag, "_all"},   32'(all_ready_h),  32'h0);
    check_eq({tag, "_ovf"},   32'(ovf_sticky),   32'h0);
    check_eq({tag, "_peak"},  32'(peak_num),     32'h0);
  endtask

  initial begin
    reset_n  = 1'b0;
    fifo_num = '0;
    clr_ovf  = '0;
    #3;
    check_all_zero("reset");
    step(2);
    reset_n = 1'b1;

    // LOW -> READY after 1 sample + 4 debounce edges
    step(5);
    set_lvl(0, 11);
    step(4);
    check_eq("rdy_early", 32'(fifo_ready_h[0]), 32'h0);
    step(1);
    check_eq("rdy_rise",   32'(fifo_ready_h[0]), 32'h1);
    check_eq("rdy_full0",  32'(fifo_full_h[0]),  32'h0);
    check_eq("rdy_ch1",    32'(fifo_ready_h[1]), 32'h0);
    check_eq("rdy_allrdy", 32'(all_ready_h),     32'h0);

    // back to LOW, then immediate FULL on a step to 1001
    set_lvl(0, 0);
    step(5);
    check_eq("low_again", 32'(fifo_ready_h[0]), 32'h0);
    set_lvl(0, 1001);
    step(1);
    check_eq("full_early", 32'(fifo_full_h[0]), 32'h0);
    step(1);
    check_eq("full_rise",  32'(fifo_full_h[0]),  32'h1);
    check_eq("full_ready", 32'(fifo_ready_h[0]), 32'h1);
    check_eq("full_any",   32'(any_full_h),      32'h1);

    // hysteresis and debounce out of FULL
    set_lvl(0, 950);
    step(10);
    check_eq("hyst_950", 32'(fifo_full_h[0]), 32'h1);
    set_lvl(0, 900);
    step(3);
    set_lvl(0, 950);
    step(10);
    check_eq("hyst_900x3", 32'(fifo_full_h[0]), 32'h1);
    set_lvl(0, 900);
    step(4);
    check_eq("drop_pre", 32'(fifo_full_h[0]), 32'h1);
    set_lvl(0, 950);
    step(1);
    check_eq("drop_full",  32'(fifo_full_h[0]),  32'h0);
    check_eq("drop_ready", 32'(fifo_ready_h[0]), 32'h1);
    check_eq("drop_any",   32'(any_full_h),      32'h0);

    // chatter between 3 and 11 never commits
    for (int k = 0; k < 20; k++) begin
      set_lvl(0, (k % 2 == 0) ? 11'd3 : 11'd11);
      step(1);
      check_eq("chatter", 32'({fifo_full_h[0], fifo_ready_h[0]}), 32'h1);
    end
    set_lvl(0, 11);
    step(3);
    check_eq("chatter_end", 32'(fifo_ready_h[0]), 32'h1);

    // sticky overflow on ch1
    set_lvl(1, 1030);
    step(1);
    set_lvl(1, 500);
    check_eq("ovf_early", 32'(ovf_sticky[1]), 32'h0);
    step(1);
    check_eq("ovf_set",  32'(ovf_sticky[1]), 32'h1);
    check_eq("ovf_ch0",  32'(ovf_sticky[0]), 32'h0);
    check_eq("ovf_any",  32'(any_full_h),    32'h1);
    step(5);
    check_eq("ovf_hold", 32'(ovf_sticky[1]), 32'h1);
    check_eq("both_rdy", 32'(all_ready_h),   32'h1);
    check_eq("both_any", 32'(any_full_h),    32'h0);
    set_lvl(1, 1030);
    step(2);
    pulse_clr(1);
    check_eq("ovf_clr_hi", 32'(ovf_sticky[1]), 32'h1);
    set_lvl(1, 500);
    step(3);
    pulse_clr(1);
    check_eq("ovf_clr_lo", 32'(ovf_sticky[1]), 32'h0);

    // async reset in the middle of a FULL -> READY debounce
    set_lvl(0, 1001);
    set_lvl(1, 1030);
    step(3);
    check_eq("pre_rst_full", 32'(fifo_full_h[0]), 32'h1);
    check_eq("pre_rst_ovf",  32'(ovf_sticky[1]),  32'h1);
    set_lvl(0, 900);
    set_lvl(1, 0);
    step(2);
    reset_n = 1'b0;
    #2;
    check_all_zero("async_rst");
    set_lvl(0, 950);
    step(2);
    reset_n = 1'b1;
    step(2);
    check_eq("post_rst_nofull", 32'(fifo_full_h[0]),  32'h0);
    step(2);
    check_eq("post_rst_wait",   32'(fifo_ready_h[0]), 32'h0);
    step(1);
    check_eq("post_rst_ready",  32'(fifo_ready_h[0]), 32'h1);
    check_eq("post_rst_full",   32'(fifo_full_h[0]),  32'h0);

    // peak tracking on ch0
    reset_n = 1'b0;
    set_lvl(0, 5);
    step(1);
    reset_n = 1'b1;
    step(2);
`ifdef FIFO_LEVEL_PEAK_EN
    check_eq("peak_5", 32'(peak_num[0 +: W]), 32'd5);
`else
    check_eq("peak_5", 32'(peak_num[0 +: W]), 32'd0);
`endif
    set_lvl(0, 700);
    step(2);
    set_lvl(0, 300);
    step(3);
`ifdef FIFO_LEVEL_PEAK_EN
    check_eq("peak_700", 32'(peak_num[0 +: W]), 32'd700);
`else
    check_eq("peak_700", 32'(peak_num[0 +: W]), 32'd0);
`endif
    pulse_clr(0);
`ifdef FIFO_LEVEL_PEAK_EN
    check_eq("peak_reload", 32'(peak_num[0 +: W]), 32'd300);
`else
    check_eq("peak_reload", 32'(peak_num), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
